mem_arbiter: RTL and testbench

Arbitrates the CPU's single memory port between the instruction-fetch requester and the data load/store requester. It sits between the datapath's fetch and load/store paths and the external memory. It sequences one outstanding transaction at a time through a request / grant / response handshake. Data accesses take priority, and a streak limit keeps fetch from being starved.

---
 rtl/control_defs_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_defs_pkg.sv
// Shared control-path definitions: memory arbiter FSM state and transaction owner.
package control_defs;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single memory port between instruction fetch and data load/store,
// one outstanding transaction at a time, data first with a fetch anti-starvation limit.
module mem_arbiter
  import control_defs::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,

  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,

  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;

  logic streak_max_c;
  logic pick_i_c;

  assign streak_max_c = (streak_q == SW'(MAX_D_STREAK));
  // Fetch wins when data is absent, or when data has used up its streak
  assign pick_i_c     = i_req && (!d_req || streak_max_c);

  // Next-state, owner and streak logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (!i_req) begin
          streak_d = '0;
        end else if (pick_i_c) begin
          streak_d = '0;
        end else if (d_req) begin
          streak_d = streak_q + SW'(1);
        end
        if (i_req || d_req) begin
          state_d = ARB_REQ;
          owner_d = pick_i_c ? OWN_I : OWN_D;
        end
      end
      ARB_REQ: begin
        if (m_gnt) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (m_rvalid) begin
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Memory-side mux and requester-side handshake routing
  always_comb begin
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_be     = '0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    if (state_q == ARB_REQ) begin
      m_req = 1'b1;
      if (owner_q == OWN_D) begin
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_be    = d_be;
        d_gnt   = m_gnt;
      end else if (owner_q == OWN_I) begin
        m_addr  = i_addr;
        m_be    = {BW{1'b1}};
        i_gnt   = m_gnt;
      end
    end
    if (state_q == ARB_WAIT && m_rvalid) begin
      if (owner_q == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end else if (owner_q == OWN_I) begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: hand-written reset/stray sequences, then a vector table of
// arbitrations served by a bench memory with a response scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  typedef struct {
    bit          ireq;
    bit          dreq;
    bit          dwe;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          gdly;
    int          rdly;
    bit          exp_d;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit ir, bit dr, bit we, logic [31:0] ia, logic [31:0] da,
                              logic [31:0] wd, logic [3:0] be, logic [31:0] rd,
                              int gd, int rdl, bit ed);
    vec_t v;
    v.ireq = ir; v.dreq = dr; v.dwe = we; v.iaddr = ia; v.daddr = da;
    v.wdata = wd; v.be = be; v.rdata = rd; v.gdly = gd; v.rdly = rdl; v.exp_d = ed;
    return v;
  endfunction

  task automatic chk_quiet(input string name);
    chk({name, "_m_req"}, 32'(m_req), 32'd0);
    chk({name, "_m_addr"}, m_addr, 32'd0);
    chk({name, "_gnts"}, {30'd0, i_gnt, d_gnt}, 32'd0);
    chk({name, "_rvalids"}, {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk({name, "_rdata"}, i_rdata | d_rdata, 32'd0);
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    logic [31:0] ea, ewd;
    logic [3:0]  ebe;
    logic        ewe;
    rsp_t        r;
    string       tag;
    tag = $sformatf("v%0d", idx);
    ea  = v.exp_d ? v.daddr : v.iaddr;
    ewe = v.exp_d ? v.dwe : 1'b0;
    ewd = v.exp_d ? v.wdata : 32'd0;
    ebe = v.exp_d ? v.be : 4'hF;

    i_req = v.ireq; i_addr = v.iaddr;
    d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.wdata; d_be = v.be;
    #1;
    chk({tag, "_idle_m_req"}, 32'(m_req), 32'd0);
    step();

    // REQ with memory stalling the grant; stray rvalid must be ignored
    for (int k = 0; k < v.gdly; k++) begin
      m_rvalid = 1'b1;
      #1;
      chk({tag, "_hold_m_req"}, 32'(m_req), 32'd1);
      chk({tag, "_hold_m_addr"}, m_addr, ea);
      chk({tag, "_hold_m_wdata"}, m_wdata, ewd);
      chk({tag, "_hold_gnts"}, {30'd0, i_gnt, d_gnt}, 32'd0);
      chk({tag, "_hold_rvalids"}, {30'd0, i_rvalid, d_rvalid}, 32'd0);
      m_rvalid = 1'b0;
      step();
    end

    m_gnt = 1'b1;
    #1;
    chk({tag, "_m_req"}, 32'(m_req), 32'd1);
    chk({tag, "_m_addr"}, m_addr, ea);
    chk({tag, "_m_we"}, 32'(m_we), 32'(ewe));
    chk({tag, "_m_wdata"}, m_wdata, ewd);
    chk({tag, "_m_be"}, 32'(m_be), 32'(ebe));
    chk({tag, "_i_gnt"}, 32'(i_gnt), 32'(!v.exp_d));
    chk({tag, "_d_gnt"}, 32'(d_gnt), 32'(v.exp_d));
    r.is_d = v.exp_d;
    r.rdata = v.rdata;
    sb.push_back(r);
    step();
    m_gnt = 1'b0;
    if (v.exp_d) d_req = 1'b0;
    else i_req = 1'b0;
    #1;
    chk({tag, "_wait_m_req"}, 32'(m_req), 32'd0);
    chk({tag, "_wait_m_addr"}, m_addr, 32'd0);

    // WAIT with delayed response; stray gnt must be ignored
    for (int k = 0; k < v.rdly; k++) begin
      m_gnt = 1'b1;
      #1;
      chk({tag, "_wait_gnts"}, {30'd0, i_gnt, d_gnt}, 32'd0);
      chk({tag, "_wait_rvalids"}, {30'd0, i_rvalid, d_rvalid}, 32'd0);
      chk({tag, "_wait_m_req2"}, 32'(m_req), 32'd0);
      m_gnt = 1'b0;
      step();
    end

    m_rvalid = 1'b1;
    m_rdata  = v.rdata;
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      r = sb.pop_front();
      chk({tag, "_i_rvalid"}, 32'(i_rvalid), 32'(!r.is_d));
      chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'(r.is_d));
      chk({tag, "_own_rdata"}, r.is_d ? d_rdata : i_rdata, r.rdata);
      chk({tag, "_other_rdata"}, r.is_d ? i_rdata : d_rdata, 32'd0);
    end
    step();
    m_rvalid = 1'b0;
    m_rdata  = 32'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

    // Reset state
    step();
    step();
    chk_quiet("reset");
    chk("reset_m_we", 32'(m_we), 32'd0);
    chk("reset_m_be", 32'(m_be), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset mid-transaction, then a late rvalid
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
    step();
    m_gnt = 1'b1;
    #1;
    chk("rst_mid_d_gnt", 32'(d_gnt), 32'd1);
    chk("rst_mid_m_addr", m_addr, 32'h100);
    step();
    m_gnt = 1'b0;
    d_req = 1'b0;
    rst_n = 1'b0;
    m_rvalid = 1'b1;
    m_rdata = 32'h1234_5678;
    #1;
    chk_quiet("in_reset");
    step();
    rst_n = 1'b1;
    #1;
    chk_quiet("late_rvalid");
    step();
    m_rvalid = 1'b0;
    m_rdata = '0;

    // Stray grant in IDLE
    m_gnt = 1'b1;
    #1;
    chk("idle_stray_gnts", {30'd0, i_gnt, d_gnt}, 32'd0);
    step();
    m_gnt = 1'b0;
    #1;
    chk("idle_stays_idle", 32'(m_req), 32'd0);

    // Arbitration table: streak starts at 0
    vecs.push_back(mk(1, 0, 0, 32'h40,  32'h0,   32'h0,        4'h0, 32'h00A0_0093, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 32'h44,  32'h200, 32'hDEADBEEF, 4'h3, 32'h0,         0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'h44,  32'h0,   32'h0,        4'h0, 32'h0000_0013, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 1, 0, 32'h48, 32'h300 + 32'(4 * k), 32'h0, 4'hF, $urandom, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 32'h48,  32'h310, 32'h0,        4'hF, 32'hF00D_0001, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 1, 1, 32'h4C, 32'h400 + 32'(4 * k), $urandom, 4'hC, 32'h0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,   32'h500, 32'h0,        4'hF, $urandom,      0, 0, 1));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 1, 0, 32'h50, 32'h600 + 32'(4 * k), 32'h0, 4'hF, $urandom, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 32'h50,  32'h610, 32'h0,        4'hF, 32'hF00D_0002, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   32'h100, 32'h0,        4'h5, 32'hBEEF_CAFE, 3, 5, 1));
    vecs.push_back(mk(1, 0, 0, 32'h80,  32'h0,   32'h0,        4'h0, 32'h1357_9BDF, 2, 1, 0));

    foreach (vecs[n]) run_txn(vecs[n], n);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
